instr_fetch_queue: RTL and testbench

//  Instruction fetch stage feeding the decode stage of the 9-bit pipelined CPU.

---
 rtl/instr_fetch_queue_if.sv | 27 ++
 rtl/instr_fetch_queue.sv | 93 +++++++++
 tb/tb_instr_fetch_queue.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bus: ROM address/data, decode handshake, branch redirect and fetch status.
interface instr_fetch_queue_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
);
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_in;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;

  modport slave (
    output pc_out, id_valid, id_instr, id_pc, halted, fetch_count,
    input  instr_in, id_ready, redirect, redirect_pc
  );

  modport master (
    input  pc_out, id_valid, id_instr, id_pc, halted, fetch_count,
    output instr_in, id_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch with a 2-entry decode queue, branch redirect flush,
// halt detection and a saturating fetch counter.
module instr_fetch_queue #(
  parameter int                 PC_W      = 8,
  parameter int                 INSTR_W   = 9,
  parameter logic [PC_W-1:0]    RESET_PC  = 8'd1,
  parameter logic [INSTR_W-1:0] HALT_WORD = 9'b110111000,
  parameter int                 CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_queue_if.slave   bus
);
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t           r_q [2];
  logic [1:0]       r_count;
  logic [PC_W-1:0]  r_pc;
  logic             r_halt_seen;
  logic             r_halted;
  logic [CNT_W-1:0] r_fetch_cnt;

  logic   w_valid;
  logic   w_deq;
  logic   w_enq;
  logic   w_is_halt;
  entry_t w_new;

  assign w_valid   = (r_count != 2'd0);
  assign w_deq     = w_valid && bus.id_ready && !bus.redirect;
  // A pop in the same cycle frees a slot even when the queue is full.
  assign w_enq     = !bus.redirect && !r_halt_seen && ((r_count < 2'd2) || w_deq);
  assign w_is_halt = (bus.instr_in == HALT_WORD);
  assign w_new     = {r_pc, bus.instr_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q[0]      <= '0;
      r_q[1]      <= '0;
      r_count     <= 2'd0;
      r_pc        <= RESET_PC;
      r_halt_seen <= 1'b0;
      r_halted    <= 1'b0;
      r_fetch_cnt <= '0;
    end else if (bus.redirect) begin
      r_count     <= 2'd0;
      r_halt_seen <= 1'b0;
      r_halted    <= 1'b0;
      r_pc        <= bus.redirect_pc;
    end else begin
      if (w_deq && (r_q[0].instr == HALT_WORD))
        r_halted <= 1'b1;
      case ({w_enq, w_deq})
        2'b10: begin
          r_q[r_count[0]] <= w_new;
          r_count         <= r_count + 2'd1;
        end
        2'b01: begin
          r_q[0]  <= r_q[1];
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_q[0] <= r_q[1];
            r_q[1] <= w_new;
          end else begin
            r_q[0] <= w_new;
          end
        end
        default: ;
      endcase
      if (w_enq) begin
        if (r_fetch_cnt != '1)
          r_fetch_cnt <= r_fetch_cnt + 1'b1;
        // Halt word parks the PC on itself so fetch stops there.
        if (w_is_halt)
          r_halt_seen <= 1'b1;
        else
          r_pc <= r_pc + 1'b1;
      end
    end
  end

  assign bus.pc_out      = r_pc;
  assign bus.id_valid    = w_valid;
  assign bus.id_instr    = w_valid ? r_q[0].instr : '0;
  assign bus.id_pc       = w_valid ? r_q[0].pc    : '0;
  assign bus.halted      = r_halted;
  assign bus.fetch_count = r_fetch_cnt;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: spec vector table, directed corner cases and
// randomized stalls/redirects against a queue-based reference model.
module tb_instr_fetch_queue;
  localparam logic [8:0] HALT = 9'b110111000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_queue_if #(.PC_W(8), .INSTR_W(9), .CNT_W(16)) bus ();
  instr_fetch_queue dut (.clk(clk), .reset(reset), .bus(bus));

  logic [8:0] rom [256];
  assign bus.instr_in = rom[bus.pc_out];

  typedef struct { logic [7:0] pc; logic [8:0] instr; } ment_t;
  ment_t      mq [$];
  logic [7:0] m_pc;
  bit         m_hs, m_halted;
  int         m_cnt;
  int         n_chk = 0, n_pass = 0;

  typedef struct {
    bit rst; bit rdy; bit redir; logic [7:0] rpc;
    logic [7:0] e_pc; bit e_vld; logic [7:0] e_idpc; int e_cnt;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.id_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    mq.delete(); m_pc = 8'd1; m_hs = 0; m_halted = 0; m_cnt = 0;
  endtask

  // Compare the DUT with the model, then advance the model by one cycle.
  task automatic step(input bit rdy, input bit redir, input logic [7:0] rpc);
    logic [8:0] w;
    ment_t e;
    bus.id_ready = rdy; bus.redirect = redir; bus.redirect_pc = rpc;
    #1;
    chk("m_pc_out",   32'(bus.pc_out),      32'(m_pc));
    chk("m_id_valid", 32'(bus.id_valid),    32'(mq.size() > 0));
    chk("m_id_pc",    32'(bus.id_pc),       mq.size() > 0 ? 32'(mq[0].pc) : 32'd0);
    chk("m_id_instr", 32'(bus.id_instr),    mq.size() > 0 ? 32'(mq[0].instr) : 32'd0);
    chk("m_halted",   32'(bus.halted),      32'(m_halted));
    chk("m_fcount",   32'(bus.fetch_count), 32'(m_cnt));
    if (redir) begin
      mq.delete(); m_hs = 0; m_halted = 0; m_pc = rpc;
    end else begin
      if (mq.size() > 0 && rdy) begin
        if (mq[0].instr == HALT) m_halted = 1;
        void'(mq.pop_front());
      end
      if (!m_hs && mq.size() < 2) begin
        w = rom[m_pc]; e.pc = m_pc; e.instr = w;
        mq.push_back(e);
        if (m_cnt != 65535) m_cnt++;
        if (w == HALT) m_hs = 1; else m_pc = m_pc + 8'd1;
      end
    end
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    logic [8:0] ei;
    logic [7:0] rpc;
    for (int a = 0; a < 256; a++) rom[a] = {1'b0, 8'(a) ^ 8'h5A};
    rom[29]  = HALT;
    rom[200] = HALT;

    // rst rdy redir rpc | pc_out valid id_pc fetch_count
    tbl[0]  = '{1, 1, 0, 0,   1,   0, 0,   0};
    tbl[1]  = '{0, 1, 0, 0,   2,   1, 1,   1};
    tbl[2]  = '{0, 1, 0, 0,   3,   1, 2,   2};
    tbl[3]  = '{0, 1, 0, 0,   4,   1, 3,   3};
    tbl[4]  = '{1, 0, 1, 17,  1,   0, 0,   0};
    tbl[5]  = '{0, 0, 0, 0,   17,  0, 0,   0};
    tbl[6]  = '{0, 0, 0, 0,   18,  1, 17,  1};
    tbl[7]  = '{0, 1, 1, 21,  19,  1, 17,  2};
    tbl[8]  = '{0, 0, 0, 0,   21,  0, 0,   2};
    tbl[9]  = '{0, 0, 0, 0,   22,  1, 21,  3};
    tbl[10] = '{1, 1, 1, 255, 1,   0, 0,   0};
    tbl[11] = '{0, 1, 0, 0,   255, 0, 0,   0};
    tbl[12] = '{0, 1, 0, 0,   0,   1, 255, 1};
    tbl[13] = '{0, 1, 0, 0,   1,   1, 0,   2};

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst) do_reset();
      ei = tbl[i].e_vld ? rom[tbl[i].e_idpc] : 9'd0;
      chk("t_pc_out",   32'(bus.pc_out),      32'(tbl[i].e_pc));
      chk("t_id_valid", 32'(bus.id_valid),    32'(tbl[i].e_vld));
      chk("t_id_pc",    32'(bus.id_pc),       32'(tbl[i].e_idpc));
      chk("t_id_instr", 32'(bus.id_instr),    32'(ei));
      chk("t_fcount",   32'(bus.fetch_count), 32'(tbl[i].e_cnt));
      step(tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
    end

    // Decode stall fills the queue, release drains in order
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("stall_pc_out", 32'(bus.pc_out), 32'd3);
    chk("stall_fcount", 32'(bus.fetch_count), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("drain_id_pc", 32'(bus.id_pc), 32'(i + 1));
      step(1, 0, 0);
    end

    // Halt at 29 stops fetch, halted after decode takes it
    do_reset();
    step(1, 1, 8'd26);
    for (int i = 0; i < 11; i++) step(1, 0, 0);
    chk("halt_pc_out",   32'(bus.pc_out),      32'd29);
    chk("halt_halted",   32'(bus.halted),      32'd1);
    chk("halt_id_valid", 32'(bus.id_valid),    32'd0);
    chk("halt_fcount",   32'(bus.fetch_count), 32'd4);

    // Halt enqueued but flushed by redirect before decode
    do_reset();
    step(0, 1, 8'd28);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 8'd20);
    step(0, 0, 0);
    chk("flush_halted", 32'(bus.halted), 32'd0);
    chk("flush_id_pc",  32'(bus.id_pc),  32'd20);
    chk("flush_pc_out", 32'(bus.pc_out), 32'd21);
    for (int i = 0; i < 4; i++) step(1, 0, 0);

    // Random stalls and redirects against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(1) == 0) ? 8'($urandom_range(31, 24)) : 8'($urandom_range(255));
      step($urandom_range(3) != 0, $urandom_range(39) == 0, rpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
